cfs_algn_ctrl_seq: RTL and testbench

CFS_ALGN_CTRL_SEQ -- requirements
Module: cfs_algn_ctrl_seq

---
 rtl/cfs_algn_ctrl_seq_if.sv | 13 +
 rtl/cfs_algn_ctrl_seq.sv | 115 +++++++++++
 tb/tb_cfs_algn_ctrl_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cfs_algn_ctrl_seq_if.sv
// cfs_algn_ctrl_seq_if: APB bus between the control sequencer (master) and the aligner register block (slave)
interface cfs_algn_ctrl_seq_if;
    logic [15:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    modport master (output paddr, pwrite, psel, penable, pwdata, input pready, prdata, pslverr);
    modport slave  (input paddr, pwrite, psel, penable, pwdata, output pready, prdata, pslverr);
endinterface

// File: rtl/cfs_algn_ctrl_seq.sv
// cfs_algn_ctrl_seq: APB master that programs and verifies the aligner CTRL register and services its IRQ register
module cfs_algn_ctrl_seq #(
    parameter logic [15:0] CTRL_ADDR = 16'h0000,
    parameter logic [15:0] IRQ_ADDR  = 16'h00F4,
    parameter logic [31:0] RDBK_MASK = 32'h0000_0307,
    parameter int          TIMEOUT   = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_start,
    input  logic [2:0]          cfg_size,
    input  logic [1:0]          cfg_offset,
    input  logic                cfg_clr,
    input  logic                irq,
    cfs_algn_ctrl_seq_if.master apb,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         irq_status,
    output logic                irq_valid
);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, NEXT} state_t;
    typedef enum logic [1:0] {CFG_WR, CFG_RD, IRQ_RD, IRQ_WR} step_t;
    state_t        state;
    step_t         step;
    logic [31:0]   cfg_word;
    logic [31:0]   wdata;
    logic [WW-1:0] wcnt;
    assign cfg_word = {15'b0, cfg_clr, 6'b0, cfg_offset, 5'b0, cfg_size};
    // Sequencer: done is high in the final cycle, so it also blocks a restart until one idle cycle has passed
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            step        <= CFG_WR;
            wdata       <= '0;
            wcnt        <= '0;
            apb.paddr   <= '0;
            apb.pwrite  <= 1'b0;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwdata  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            irq_status  <= '0;
            irq_valid   <= 1'b0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            irq_valid <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (!done && (cfg_start || irq)) begin
                        state      <= SETUP;
                        busy       <= 1'b1;
                        apb.psel   <= 1'b1;
                        step       <= cfg_start ? CFG_WR : IRQ_RD;
                        apb.paddr  <= cfg_start ? CTRL_ADDR : IRQ_ADDR;
                        apb.pwrite <= cfg_start;
                        apb.pwdata <= cfg_start ? cfg_word : '0;
                        wdata      <= cfg_start ? cfg_word : wdata;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    apb.penable <= 1'b1;
                    wcnt        <= '0;
                end
                ACCESS: begin
                    if (apb.pready || wcnt == WW'(TIMEOUT - 1)) begin
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        wcnt        <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                    if (!apb.pready && wcnt == WW'(TIMEOUT - 1) || apb.pready && apb.pslverr) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (apb.pready) begin
                        state <= NEXT;
                        case (step)
                            CFG_WR: begin
                                step       <= CFG_RD;
                                apb.pwrite <= 1'b0;
                                apb.pwdata <= '0;
                            end
                            CFG_RD: begin
                                done <= 1'b1;
                                err  <= |((apb.prdata ^ wdata) & RDBK_MASK);
                            end
                            IRQ_RD: begin
                                irq_status <= apb.prdata;
                                irq_valid  <= 1'b1;
                                done       <= apb.prdata == '0;
                                step       <= IRQ_WR;
                                apb.pwrite <= 1'b1;
                                apb.pwdata <= apb.prdata;
                            end
                            IRQ_WR: done <= 1'b1;
                        endcase
                    end
                end
                NEXT: begin
                    state    <= done ? IDLE : SETUP;
                    busy     <= !done;
                    apb.psel <= !done;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cfs_algn_ctrl_seq.sv
// tb_cfs_algn_ctrl_seq: table-driven, hand-written and randomized checks of the APB control sequencer
module tb_cfs_algn_ctrl_seq;
    localparam logic [15:0] CA   = 16'h0000;
    localparam logic [15:0] IA   = 16'h00F4;
    localparam logic [31:0] MASK = 32'h0000_0307;
    localparam int          TO   = 15;
    typedef struct {logic [15:0] a; logic w; logic [31:0] d;} xfer_t;
    typedef struct {
        bit c; logic [2:0] sz; logic [1:0] of; logic cl; logic [31:0] rd;
        int w0; int w1; int si; bit e; int lat;
    } vec_t;
    logic clk = 0, reset = 1, cfg_start = 0, cfg_clr = 0, irq = 0;
    logic [2:0] cfg_size = 0;
    logic [1:0] cfg_offset = 0;
    logic busy, done, err, irq_valid;
    logic [31:0] irq_status;
    int n_cmp = 0, n_bad = 0, p_err = 0;
    int acnt = 0, xi = 0, base = 0, serr_i = -1, cur_w;
    int wv[2] = '{0, 0};
    logic [31:0] rdv = 0, exp_status = 0;
    xfer_t lq[$];
    logic pp_sel = 0, pp_done = 0, pp_w = 0;
    logic [15:0] pp_a = 0;
    logic [31:0] pp_d = 0;
    cfs_algn_ctrl_seq_if bus();
    cfs_algn_ctrl_seq dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_size(cfg_size),
        .cfg_offset(cfg_offset), .cfg_clr(cfg_clr), .irq(irq), .apb(bus.master),
        .busy(busy), .done(done), .err(err), .irq_status(irq_status), .irq_valid(irq_valid)
    );
    always #5 clk = ~clk;
    // Slave model: per-transfer wait count, shared read data, error on a chosen transfer index
    always_comb cur_w = wv[(xi - base) & 1];
    assign bus.pready  = bus.psel && bus.penable && (acnt >= cur_w);
    assign bus.prdata  = rdv;
    assign bus.pslverr = bus.pready && ((xi - base) == serr_i);
    always @(posedge clk) begin
        acnt <= (bus.psel && bus.penable && !bus.pready) ? acnt + 1 : 0;
        if (bus.psel && bus.penable && bus.pready) xi <= xi + 1;
    end
    // Bus monitor: logs completed transfers and checks setup/access stability and the idle gap
    always @(negedge clk) begin
        if (bus.psel && bus.penable && bus.pready) lq.push_back('{bus.paddr, bus.pwrite, bus.pwdata});
        if (bus.penable && !(pp_sel && bus.psel && pp_a == bus.paddr && pp_w == bus.pwrite && pp_d == bus.pwdata)) begin
            p_err <= p_err + 1;
            $display("FAIL apb_access: psel=%b paddr=%h pwdata=%h, required stable from setup paddr=%h pwdata=%h",
                     bus.psel, bus.paddr, bus.pwdata, pp_a, pp_d);
        end
        if (pp_done && bus.psel) begin
            p_err <= p_err + 1;
            $display("FAIL apb_gap: psel=1 right after a completed transfer, required 0");
        end
        pp_sel  <= bus.psel;
        pp_a    <= bus.paddr;
        pp_w    <= bus.pwrite;
        pp_d    <= bus.pwdata;
        pp_done <= bus.psel && bus.penable && bus.pready;
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // Reference: list of operations, each costing setup + waits + access + one trailing cycle
    function automatic void model(input bit c, input logic [2:0] sz, input logic [1:0] of, input logic cl,
                                  input logic [31:0] rd, input int w0, input int w1, input int si,
                                  output bit e, output int lat, output int n, output bit iv,
                                  output xfer_t x0, output xfer_t x1);
        logic [31:0] word;
        word = {15'b0, cl, 6'b0, of, 5'b0, sz};
        e = 0; lat = 0; n = 0; iv = 0;
        x0 = c ? '{CA, 1'b1, word} : '{IA, 1'b0, 32'h0};
        x1 = c ? '{CA, 1'b0, 32'h0} : '{IA, 1'b1, rd};
        for (int i = 0; i < 2; i++) begin
            int w;
            w = i == 0 ? w0 : w1;
            if (w >= TO) begin
                lat += 2 + TO; e = 1; return;
            end
            lat += 3 + w; n = i + 1;
            if (si == i) begin
                e = 1; return;
            end
            if (!c && i == 0) begin
                iv = 1;
                if (rd == 0) return;
            end
            if (c && i == 1) e = ((rd ^ word) & MASK) != 0;
        end
    endfunction
    task automatic run(input string tag, input bit c, input logic [2:0] sz, input logic [1:0] of, input logic cl,
                       input logic [31:0] rd, input int w0, input int w1, input int si, input bit te, input int tl);
        bit e, iv, bz;
        int ml, n, lat, lb, ivc;
        xfer_t x0, x1, xe;
        model(c, sz, of, cl, rd, w0, w1, si, e, ml, n, iv, x0, x1);
        @(negedge clk);
        rdv = rd; wv[0] = w0; wv[1] = w1; serr_i = si; base = xi; lb = lq.size();
        cfg_size = sz; cfg_offset = of; cfg_clr = cl;
        if (c) cfg_start = 1; else irq = 1;
        @(negedge clk);
        cfg_start = 0; irq = 0; lat = 1; bz = 1; ivc = 0;
        while (!done && lat < 100) begin
            bz &= busy; ivc += int'(irq_valid);
            @(negedge clk);
            lat++;
        end
        bz &= busy; ivc += int'(irq_valid);
        chk({tag, " latency"}, lat, tl);
        chk({tag, " err"}, err, te);
        chk({tag, " busy"}, bz, 1);
        chk({tag, " nxfer"}, lq.size() - lb, n);
        for (int i = 0; i < n && lb + i < lq.size(); i++) begin
            xe = i == 0 ? x0 : x1;
            chk({tag, " paddr"}, lq[lb + i].a, xe.a);
            chk({tag, " pwrite"}, lq[lb + i].w, xe.w);
            if (xe.w) chk({tag, " pwdata"}, lq[lb + i].d, xe.d);
        end
        chk({tag, " irq_valid"}, ivc, iv);
        if (iv) exp_status = rd;
        chk({tag, " irq_status"}, irq_status, exp_status);
        @(negedge clk);
        chk({tag, " after_done"}, {busy, done, bus.psel}, 0);
    endtask
    initial begin
        vec_t tbl[12];
        int lat, lb, seen;
        bit e, iv;
        int ml, n;
        xfer_t x0, x1;
        tbl[0]  = '{1, 3'd4, 2'd1, 0, 32'h0000_0104, 0, 0, -1, 0, 6};
        tbl[1]  = '{1, 3'd4, 2'd1, 0, 32'h0000_0004, 0, 0, -1, 1, 6};
        tbl[2]  = '{1, 3'd7, 2'd3, 1, 32'h0000_0307, 0, 0, -1, 0, 6};
        tbl[3]  = '{1, 3'd4, 2'd1, 0, 32'h0000_01FC, 0, 0, -1, 0, 6};
        tbl[4]  = '{0, 3'd0, 2'd0, 0, 32'h0000_0011, 0, 0, -1, 0, 6};
        tbl[5]  = '{0, 3'd0, 2'd0, 0, 32'h0000_0000, 0, 0, -1, 0, 3};
        tbl[6]  = '{1, 3'd4, 2'd1, 0, 32'h0000_0104, 100, 0, -1, 1, 17};
        tbl[7]  = '{1, 3'd4, 2'd1, 0, 32'h0000_0104, 3, 14, -1, 0, 23};
        tbl[8]  = '{1, 3'd2, 2'd2, 1, 32'h0000_0202, 0, 15, -1, 1, 20};
        tbl[9]  = '{1, 3'd1, 2'd0, 0, 32'h0000_0001, 0, 0, 0, 1, 3};
        tbl[10] = '{0, 3'd0, 2'd0, 0, 32'h8000_0001, 0, 0, 1, 1, 6};
        tbl[11] = '{0, 3'd0, 2'd0, 0, 32'h0000_0005, 20, 0, -1, 1, 17};
        repeat (3) @(negedge clk);
        chk("reset apb", {bus.psel, bus.penable, bus.pwrite, bus.paddr, 16'h0}, 0);
        chk("reset pwdata", bus.pwdata, 0);
        chk("reset ctl", {busy, done, err, irq_valid}, 0);
        chk("reset irq_status", irq_status, 0);
        reset = 0;
        for (int i = 0; i < 12; i++)
            run($sformatf("vec%0d", i), tbl[i].c, tbl[i].sz, tbl[i].of, tbl[i].cl, tbl[i].rd,
                tbl[i].w0, tbl[i].w1, tbl[i].si, tbl[i].e, tbl[i].lat);
        // Reset during ACCESS abandons the sequence
        @(negedge clk);
        wv[0] = 50; wv[1] = 0; serr_i = -1; base = xi; cfg_size = 4; cfg_offset = 1; cfg_start = 1;
        @(negedge clk); cfg_start = 0;
        repeat (2) @(negedge clk);
        chk("rst_mid in_access", {bus.psel, bus.penable}, 2'b11);
        reset = 1;
        @(negedge clk);
        chk("rst_mid apb", {bus.psel, bus.penable, bus.pwrite, bus.paddr, 16'h0}, 0);
        chk("rst_mid ctl", {busy, done, err, irq_valid}, 0);
        chk("rst_mid irq_status", irq_status, 0);
        exp_status = 0; reset = 0; seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen += int'(done) + int'(bus.psel);
        end
        chk("rst_mid abandoned", seen, 0);
        // cfg_start and irq together: CFG first, IRQ after one idle cycle
        @(negedge clk);
        rdv = 0; wv[0] = 0; wv[1] = 0; base = xi; lb = lq.size();
        cfg_size = 0; cfg_offset = 0; cfg_clr = 0; cfg_start = 1; irq = 1;
        @(negedge clk); cfg_start = 0; lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("both cfg_latency", lat, 6);
        chk("both cfg_err", err, 0);
        chk("both cfg_first", lq.size() > lb ? {lq[lb].a, 15'h0, lq[lb].w} : 32'hDEAD, {CA, 16'h1});
        @(negedge clk);
        chk("both idle_gap", {bus.psel, busy}, 0);
        @(negedge clk);
        chk("both irq_setup", {15'h0, bus.psel, bus.paddr}, {16'h1, IA});
        irq = 0; lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("both irq_done", {done, err}, 2'b10);
        chk("both irq_nxfer", lq.size() - lb, 3);
        // cfg_start while busy is ignored, not queued
        @(negedge clk);
        rdv = 32'h104; wv[0] = 2; base = xi; lb = lq.size(); cfg_size = 4; cfg_offset = 1; cfg_start = 1;
        @(negedge clk); cfg_start = 0;
        repeat (2) @(negedge clk);
        cfg_start = 1;
        @(negedge clk); cfg_start = 0; lat = 4;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_start latency", lat, 8);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen += int'(bus.psel);
        end
        chk("busy_start ignored", seen, 0);
        chk("busy_start nxfer", lq.size() - lb, 2);
        // Randomized sequences against the reference
        for (int k = 0; k < 40; k++) begin
            bit c;
            logic [2:0] sz;
            logic [1:0] of;
            logic cl;
            logic [31:0] rd;
            int w0, w1, si;
            c = 1'($urandom); sz = 3'($urandom); of = 2'($urandom); cl = 1'($urandom);
            rd = c ? ({15'b0, cl, 6'b0, of, 5'b0, sz} ^ ($urandom_range(0, 2) == 0 ? $urandom : 32'h0))
                   : ($urandom_range(0, 3) == 0 ? 32'h0 : $urandom);
            w0 = $urandom_range(0, 4) == 0 ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
            w1 = $urandom_range(0, 4) == 0 ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
            si = $urandom_range(0, 5) == 0 ? int'($urandom_range(0, 1)) : -1;
            model(c, sz, of, cl, rd, w0, w1, si, e, ml, n, iv, x0, x1);
            run($sformatf("rnd%0d", k), c, sz, of, cl, rd, w0, w1, si, e, ml);
        end
        @(negedge clk);
        chk("apb_protocol violations", p_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
